// File: rtl/sdram_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of the SDRAM controller.
// One 32-bit word per line; valid bits are cleared by an index sweep after reset and on flush.
module sdram_wt_cache #(
  parameter int ADDR_WIDTH = 25,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wmask,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  busy,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ready
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [ADDR_WIDTH-1:2] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  hit_q, hit_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  mvalid_q, mvalid_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [31:0]           mdin_q, mdin_d;
  logic [3:0]            mwmask_q, mwmask_d;

  logic [31:0]           data_ram [LINES];
  logic [TAG_W-1:0]      tag_ram  [LINES];
  logic [31:0]           data_rd;
  logic [TAG_W-1:0]      tag_rd;
  logic [LINES-1:0]      valid_q;

  logic                  rd_en, data_we, tag_we, valid_clr, hit;
  logic [31:0]           data_wr, merged;
  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign idx_q = addr_q[INDEX_BITS+1:2];
  assign tag_q = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit   = valid_q[idx_q] && (tag_rd == tag_q);

  always_comb begin
    merged = data_rd;
    for (int b = 0; b < 4; b++)
      if (wmask_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
  end

  always_comb begin
    state_d = state_q; sweep_d = sweep_q; addr_d = addr_q; wdata_d = wdata_q;
    wmask_d = wmask_q; hit_d = hit_q; rdata_d = rdata_q; ready_d = 1'b0;
    busy_d = busy_q; mvalid_d = mvalid_q; maddr_d = maddr_q; mdin_d = mdin_q;
    mwmask_d = mwmask_q;
    rd_en = 1'b0; data_we = 1'b0; tag_we = 1'b0; valid_clr = 1'b0; data_wr = mem_dout;
    case (state_q)
      S_INIT: begin
        valid_clr = 1'b1;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (flush) begin
          state_d = S_INIT;
          sweep_d = '0;
          busy_d  = 1'b1;
        end else if (cpu_valid && !ready_q) begin
          // ready_q blocks re-accepting a valid still held during the response cycle
          addr_d  = cpu_addr[ADDR_WIDTH-1:2];
          wdata_d = cpu_wdata;
          wmask_d = cpu_wmask;
          rd_en   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = hit;
        if (wmask_q == 4'd0 && hit) begin
          rdata_d = data_rd;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          mvalid_d = 1'b1;
          maddr_d  = {addr_q, 2'b00};
          mdin_d   = wdata_q;
          mwmask_d = wmask_q;
          state_d  = (wmask_q == 4'd0) ? S_MEM_RD : S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          mvalid_d = 1'b0;
          data_we  = 1'b1;
          tag_we   = 1'b1;
          rdata_d  = mem_dout;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          mvalid_d = 1'b0;
          data_we  = hit_q;
          data_wr  = merged;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (reset) begin
      data_we = 1'b0;
      tag_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT; sweep_q <= '0; addr_q <= '0; wdata_q <= '0; wmask_q <= '0;
      hit_q <= 1'b0; rdata_q <= '0; ready_q <= 1'b0; busy_q <= 1'b1; mvalid_q <= 1'b0;
      maddr_q <= '0; mdin_q <= '0; mwmask_q <= '0;
    end else begin
      state_q <= state_d; sweep_q <= sweep_d; addr_q <= addr_d; wdata_q <= wdata_d;
      wmask_q <= wmask_d; hit_q <= hit_d; rdata_q <= rdata_d; ready_q <= ready_d;
      busy_q <= busy_d; mvalid_q <= mvalid_d; maddr_q <= maddr_d; mdin_q <= mdin_d;
      mwmask_q <= mwmask_d;
    end
  end

  // Arrays carry no reset; the INIT sweep makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      data_rd <= data_ram[cpu_addr[INDEX_BITS+1:2]];
      tag_rd  <= tag_ram[cpu_addr[INDEX_BITS+1:2]];
    end
    if (data_we) data_ram[idx_q] <= data_wr;
    if (tag_we)  tag_ram[idx_q]  <= tag_q;
    if (valid_clr)   valid_q[sweep_q] <= 1'b0;
    else if (tag_we) valid_q[idx_q]   <= 1'b1;
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign busy      = busy_q;
  assign mem_valid = mvalid_q;
  assign mem_addr  = maddr_q;
  assign mem_din   = mdin_q;
  assign mem_wmask = mwmask_q;
endmodule
